// File: rtl/dither_frame_sequencer_if.sv
// Bus bundle between the frame sequencer and its MCU, engine, SRAM-mux and stream neighbours.
interface dither_frame_sequencer_if #(
  parameter int unsigned ADDR_W   = 12,
  parameter int unsigned RGB_SIZE = 8
) ();
  localparam int unsigned MEM_AW = 16;

  logic                start;
  logic                abort;
  logic                spi_valid;
  logic [RGB_SIZE-1:0] spi_data;
  logic                mcu_rx_rdy;
  logic                engine_start;
  logic [ADDR_W-1:0]   engine_idx;
  logic                engine_done;
  logic [1:0]          mem_sel;
  logic [MEM_AW-1:0]   mem_addr;
  logic [RGB_SIZE-1:0] mem_wdata;
  logic                mem_wren;
  logic                mem_rden;
  logic [RGB_SIZE-1:0] mem_q;
  logic                out_valid;
  logic [RGB_SIZE-1:0] out_data;
  logic                out_ready;
  logic                busy;
  logic                frame_done;
  logic                timeout_err;
  logic [2:0]          state;

  // Sequencer side.
  modport master (
    input  start, abort, spi_valid, spi_data, engine_done, mem_q, out_ready,
    output mcu_rx_rdy, engine_start, engine_idx, mem_sel, mem_addr, mem_wdata,
           mem_wren, mem_rden, out_valid, out_data, busy, frame_done, timeout_err, state
  );

  // Environment side (MCU, engine, SRAM mux, stream sink).
  modport slave (
    output start, abort, spi_valid, spi_data, engine_done, mem_q, out_ready,
    input  mcu_rx_rdy, engine_start, engine_idx, mem_sel, mem_addr, mem_wdata,
           mem_wren, mem_rden, out_valid, out_data, busy, frame_done, timeout_err, state
  );
endinterface

// File: rtl/dither_frame_sequencer.sv
// Frame scheduler: LOAD (SPI bytes into SRAM), DITHER (per-pixel engine handshake),
// STREAM (SRAM read-back to the output byte stream), with single-owner SRAM arbitration.
module dither_frame_sequencer #(
  parameter int unsigned IMAGEX           = 64,
  parameter int unsigned IMAGEY           = 64,
  parameter int unsigned IMAGE_SIZE       = IMAGEX * IMAGEY,
  parameter int unsigned IMAGE_ADDR_WIDTH = $clog2(IMAGE_SIZE),
  parameter int unsigned RGB_SIZE         = 8,
  parameter int unsigned TIMEOUT_CYCLES   = 64
) (
  input logic                      clk,
  input logic                      rst,
  dither_frame_sequencer_if.master bus
);
  localparam int unsigned MEM_AW = 16;
  localparam int unsigned TMO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IMAGE_ADDR_WIDTH-1:0] LAST_IDX = IMAGE_ADDR_WIDTH'(IMAGE_SIZE - 1);
  localparam logic [TMO_W-1:0]            TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_D_ISSUE = 3'd2,
    ST_D_WAIT  = 3'd3,
    ST_S_RD    = 3'd4,
    ST_S_CAP   = 3'd5,
    ST_S_HOLD  = 3'd6,
    ST_DONE    = 3'd7
  } state_t;

  state_t                      state_q, state_d;
  logic [IMAGE_ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [TMO_W-1:0]            tmo_q, tmo_d;
  logic                        out_valid_q, out_valid_d;
  logic [RGB_SIZE-1:0]         out_data_q, out_data_d;
  logic                        terr_q, terr_d;

  logic [1:0]                  mem_sel_c;
  logic                        rx_rdy_c;
  logic                        wren_c;
  logic                        rden_c;
  logic [MEM_AW-1:0]           addr_c;
  logic [RGB_SIZE-1:0]         wdata_c;
  logic                        estart_c;
  logic [IMAGE_ADDR_WIDTH-1:0] eidx_c;

  // State and datapath registers; reset clears every registered output immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      tmo_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      terr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      tmo_q       <= tmo_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      terr_q      <= terr_d;
    end
  end

  // Next-state logic and per-state SRAM/engine strobes; abort overrides the transition only.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    tmo_d       = tmo_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    terr_d      = terr_q;
    mem_sel_c   = 2'd0;
    rx_rdy_c    = 1'b0;
    wren_c      = 1'b0;
    rden_c      = 1'b0;
    addr_c      = '0;
    wdata_c     = '0;
    estart_c    = 1'b0;
    eidx_c      = '0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_LOAD;
          idx_d   = '0;
          terr_d  = 1'b0;
        end
      end
      ST_LOAD: begin
        mem_sel_c = 2'd1;
        rx_rdy_c  = 1'b1;
        if (bus.spi_valid) begin
          wren_c  = 1'b1;
          addr_c  = MEM_AW'(idx_q);
          wdata_c = bus.spi_data;
          if (idx_q == LAST_IDX) begin
            state_d = ST_D_ISSUE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IMAGE_ADDR_WIDTH'(1);
          end
        end
      end
      ST_D_ISSUE: begin
        mem_sel_c = 2'd2;
        estart_c  = 1'b1;
        eidx_c    = idx_q;
        tmo_d     = '0;
        state_d   = ST_D_WAIT;
      end
      ST_D_WAIT: begin
        mem_sel_c = 2'd2;
        tmo_d     = tmo_q + TMO_W'(1);
        // A done on the final allowed cycle still wins over the timeout.
        if (bus.engine_done) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_S_RD;
            idx_d   = '0;
          end else begin
            state_d = ST_D_ISSUE;
            idx_d   = idx_q + IMAGE_ADDR_WIDTH'(1);
          end
        end else if (tmo_q == TMO_LAST) begin
          terr_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_S_RD: begin
        mem_sel_c = 2'd3;
        rden_c    = 1'b1;
        addr_c    = MEM_AW'(idx_q);
        state_d   = ST_S_CAP;
      end
      ST_S_CAP: begin
        mem_sel_c   = 2'd3;
        out_data_d  = bus.mem_q;
        out_valid_d = 1'b1;
        state_d     = ST_S_HOLD;
      end
      ST_S_HOLD: begin
        mem_sel_c = 2'd3;
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          if (idx_q == LAST_IDX) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_S_RD;
            idx_d   = idx_q + IMAGE_ADDR_WIDTH'(1);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (bus.abort) begin
      state_d     = ST_IDLE;
      out_valid_d = 1'b0;
      idx_d       = '0;
      terr_d      = terr_q;
    end
  end

  assign bus.mem_sel      = mem_sel_c;
  assign bus.mcu_rx_rdy   = rx_rdy_c;
  assign bus.mem_wren     = wren_c;
  assign bus.mem_rden     = rden_c;
  assign bus.mem_addr     = addr_c;
  assign bus.mem_wdata    = wdata_c;
  assign bus.engine_start = estart_c;
  assign bus.engine_idx   = eidx_c;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_data     = out_data_q;
  assign bus.timeout_err  = terr_q;
  assign bus.busy         = (state_q != ST_IDLE);
  assign bus.frame_done   = (state_q == ST_DONE);
  assign bus.state        = state_q;
endmodule

// File: tb/tb_dither_frame_sequencer.sv
// Randomized bench for dither_frame_sequencer with a phase/count-level reference model.
module tb_dither_frame_sequencer;
  localparam int unsigned IMAGEX = 4;
  localparam int unsigned IMAGEY = 4;
  localparam int unsigned N      = IMAGEX * IMAGEY;
  localparam int unsigned AW     = $clog2(N);
  localparam int unsigned TO     = 64;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start_main = 1'b0;
  logic start_noise = 1'b0;
  logic eng_done_m = 1'b0;
  logic eng_done_inj = 1'b0;

  dither_frame_sequencer_if #(.ADDR_W(AW), .RGB_SIZE(8)) intf ();

  dither_frame_sequencer #(
    .IMAGEX(IMAGEX), .IMAGEY(IMAGEY), .RGB_SIZE(8), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(intf)
  );

  always #5 clk = ~clk;

  assign intf.start       = start_main | start_noise;
  assign intf.engine_done = eng_done_m | eng_done_inj;

  // SRAM model behind the external port mux.
  logic [7:0] sram [N];
  always @(posedge clk) begin
    if (intf.mem_wren) sram[intf.mem_addr[AW-1:0]] <= intf.mem_wdata;
    if (intf.mem_rden) intf.mem_q <= sram[intf.mem_addr[AW-1:0]];
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Stimulus knobs.
  int spi_pct = 100;
  bit spi_seq = 1'b0;
  int rdy_pct = 100;
  int eng_fix = 2;
  int eng_max = 4;
  int skip_idx = -1;
  bit noise = 1'b0;
  int stall_idx = -1;
  int stall_left = 0;
  int stall_seen = 0;

  // Reference model: frame phase (0 idle, 1 load, 2 dither, 3 stream, 4 done),
  // pixel counts per phase and the cycle position inside the current pixel slot.
  int mphase = 0;
  int nld = 0;
  int neng = 0;
  int nout = 0;
  int slot = 0;
  bit terr_m = 1'b0;
  logic [7:0] pix [N];
  int n_fd = 0;
  int engq[$];
  int outq[$];

  // Compare process: every cycle, outputs against the model, then advance the model.
  always @(negedge clk) begin
    int es;
    int esel;
    if (!rst) begin
      mphase = 0;
      slot   = 0;
      terr_m = 1'b0;
    end else begin
      case (mphase)
        1: es = 1;
        2: es = (slot == 0) ? 2 : 3;
        3: es = (slot == 0) ? 4 : ((slot == 1) ? 5 : 6);
        4: es = 7;
        default: es = 0;
      endcase
      esel = (mphase >= 1 && mphase <= 3) ? mphase : 0;
      check("busy", 32'(intf.busy), 32'(mphase != 0));
      check("state", 32'(intf.state), 32'(es));
      check("mem_sel", 32'(intf.mem_sel), 32'(esel));
      check("mcu_rx_rdy", 32'(intf.mcu_rx_rdy), 32'(mphase == 1));
      check("mem_wren", 32'(intf.mem_wren), 32'(mphase == 1 && intf.spi_valid));
      if (mphase == 1 && intf.spi_valid) begin
        check("wr_addr", 32'(intf.mem_addr), 32'(nld));
        check("wr_data", 32'(intf.mem_wdata), 32'(intf.spi_data));
      end
      check("engine_start", 32'(intf.engine_start), 32'(mphase == 2 && slot == 0));
      if (mphase == 2 && slot == 0) check("engine_idx", 32'(intf.engine_idx), 32'(neng));
      check("mem_rden", 32'(intf.mem_rden), 32'(mphase == 3 && slot == 0));
      if (mphase == 3 && slot == 0) check("rd_addr", 32'(intf.mem_addr), 32'(nout));
      check("out_valid", 32'(intf.out_valid), 32'(mphase == 3 && slot >= 2));
      if (mphase == 3 && slot >= 2) check("out_data", 32'(intf.out_data), 32'(pix[nout]));
      check("frame_done", 32'(intf.frame_done), 32'(mphase == 4));
      check("timeout_err", 32'(intf.timeout_err), 32'(terr_m));

      if (intf.engine_start) engq.push_back(int'(intf.engine_idx));
      if (intf.out_valid && intf.out_ready) outq.push_back(int'(intf.out_data));
      if (intf.frame_done) n_fd++;

      if (intf.abort) begin
        mphase = 0;
        slot   = 0;
      end else begin
        case (mphase)
          0: if (intf.start) begin
            mphase = 1; nld = 0; neng = 0; nout = 0; slot = 0; terr_m = 1'b0;
          end
          1: if (intf.spi_valid) begin
            pix[nld] = intf.spi_data;
            nld++;
            if (nld == N) begin mphase = 2; slot = 0; end
          end
          2: begin
            if (slot == 0) slot = 1;
            else if (intf.engine_done) begin
              neng++;
              slot = 0;
              if (neng == N) mphase = 3;
            end else if (slot == TO) begin
              terr_m = 1'b1;
              mphase = 0;
              slot   = 0;
            end else slot++;
          end
          3: begin
            if (slot < 2) slot++;
            else if (intf.out_ready) begin
              nout++;
              slot = 0;
              if (nout == N) mphase = 4;
            end
          end
          default: mphase = 0;
        endcase
      end
    end
  end

  // Per-cycle input driver, just after the active edge.
  initial begin
    intf.spi_valid = 1'b0;
    intf.spi_data  = '0;
    intf.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      intf.spi_valid = ($urandom_range(99) < spi_pct);
      intf.spi_data  = spi_seq ? 8'(nld) : 8'($urandom);
      if (stall_left > 0 && mphase == 3 && nout == stall_idx && intf.out_valid) begin
        intf.out_ready = 1'b0;
        stall_left--;
        stall_seen++;
      end else begin
        intf.out_ready = ($urandom_range(99) < rdy_pct);
      end
      if (noise && (mphase == 1 || mphase == 3)) begin
        start_noise  = ($urandom_range(99) < 15);
        eng_done_inj = (mphase == 1) && ($urandom_range(99) < 15);
      end else begin
        start_noise  = 1'b0;
        eng_done_inj = 1'b0;
      end
    end
  end

  // Engine model: answers each start after a delay; one index may be left unanswered.
  initial begin
    int d;
    forever begin
      @(negedge clk);
      if (rst && intf.engine_start && int'(intf.engine_idx) != skip_idx) begin
        d = (eng_fix > 0) ? eng_fix : int'($urandom_range(eng_max, 1));
        repeat (d) @(posedge clk);
        #1 eng_done_m = 1'b1;
        @(posedge clk);
        #1 eng_done_m = 1'b0;
      end
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1 start_main = 1'b1;
    @(posedge clk); #1 start_main = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int k = 0;
    @(negedge clk);
    while (intf.busy === 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check({name, "_idle_bound"}, 32'(k < budget), 32'd1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int fd0;
    int k;
    intf.abort = 1'b0;
    rst = 1'b0;
    #12;
    check("rst_busy", 32'(intf.busy), 32'd0);
    check("rst_state", 32'(intf.state), 32'd0);
    check("rst_out_valid", 32'(intf.out_valid), 32'd0);
    check("rst_out_data", 32'(intf.out_data), 32'd0);
    check("rst_timeout_err", 32'(intf.timeout_err), 32'd0);
    check("rst_mem_sel", 32'(intf.mem_sel), 32'd0);
    check("rst_mcu_rx_rdy", 32'(intf.mcu_rx_rdy), 32'd0);
    @(negedge clk); #2 rst = 1'b1;
    repeat (3) @(posedge clk);

    // Full frame, sequential bytes, fixed engine latency, sink always ready.
    spi_pct = 100; spi_seq = 1'b1; eng_fix = 2; rdy_pct = 100;
    engq.delete(); outq.delete(); fd0 = n_fd;
    pulse_start();
    wait_idle("t1", 3000);
    check("t1_eng_count", 32'(engq.size()), 32'(N));
    check("t1_out_count", 32'(outq.size()), 32'(N));
    for (int i = 0; i < N; i++) begin
      check("t1_eng_idx", 32'((i < engq.size()) ? engq[i] : -1), 32'(i));
      check("t1_out_byte", 32'((i < outq.size()) ? outq[i] : -1), 32'(i));
    end
    check("t1_frame_done", 32'(n_fd - fd0), 32'd1);
    check("t1_busy", 32'(intf.busy), 32'd0);

    // Gappy SPI, random engine latency, random sink backpressure.
    spi_seq = 1'b0; spi_pct = 40; eng_fix = 0; eng_max = 5; rdy_pct = 60;
    for (int f = 0; f < 3; f++) begin
      fd0 = n_fd;
      pulse_start();
      wait_idle("t2", 3000);
      check("t2_frame_done", 32'(n_fd - fd0), 32'd1);
    end

    // Engine never answers pixel 5.
    spi_pct = 100; eng_fix = 3; rdy_pct = 100; skip_idx = 5;
    engq.delete(); fd0 = n_fd;
    pulse_start();
    wait_idle("t3", 3000);
    check("t3_timeout_err", 32'(intf.timeout_err), 32'd1);
    check("t3_state", 32'(intf.state), 32'd0);
    check("t3_busy", 32'(intf.busy), 32'd0);
    check("t3_last_eng_idx", 32'((engq.size() > 0) ? engq[engq.size()-1] : -1), 32'd5);
    check("t3_no_frame_done", 32'(n_fd - fd0), 32'd0);

    // Next start clears the error; engine answers on the last allowed cycle.
    skip_idx = -1; eng_fix = TO; fd0 = n_fd;
    pulse_start();
    @(negedge clk);
    check("t3_err_cleared", 32'(intf.timeout_err), 32'd0);
    wait_idle("t3b", 3000);
    check("t3b_frame_done", 32'(n_fd - fd0), 32'd1);
    check("t3b_timeout_err", 32'(intf.timeout_err), 32'd0);

    // Sink stalls 10 cycles on pixel 3.
    eng_fix = 1; rdy_pct = 100; stall_idx = 3; stall_left = 10; stall_seen = 0; fd0 = n_fd;
    pulse_start();
    wait_idle("t4", 3000);
    check("t4_stall_cycles", 32'(stall_seen), 32'd10);
    check("t4_frame_done", 32'(n_fd - fd0), 32'd1);
    stall_idx = -1;

    // Abort while waiting on pixel 7.
    eng_fix = 20;
    pulse_start();
    k = 0;
    @(negedge clk);
    while (!(intf.engine_start === 1'b1 && int'(intf.engine_idx) == 7) && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check("t5_reach_idx7", 32'(k < 2000), 32'd1);
    @(posedge clk); #1 intf.abort = 1'b1;
    @(posedge clk); #1 intf.abort = 1'b0;
    @(negedge clk);
    check("t5_abort_state", 32'(intf.state), 32'd0);
    check("t5_abort_out_valid", 32'(intf.out_valid), 32'd0);
    repeat (30) @(posedge clk);

    // Reset mid-stream clears outputs with no clock edge.
    eng_fix = 1; rdy_pct = 50;
    pulse_start();
    k = 0;
    @(negedge clk);
    while (intf.out_valid !== 1'b1 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check("t5_reach_stream", 32'(k < 2000), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("t5_rst_busy", 32'(intf.busy), 32'd0);
    check("t5_rst_state", 32'(intf.state), 32'd0);
    check("t5_rst_out_valid", 32'(intf.out_valid), 32'd0);
    check("t5_rst_out_data", 32'(intf.out_data), 32'd0);
    check("t5_rst_mem_sel", 32'(intf.mem_sel), 32'd0);
    check("t5_rst_mem_rden", 32'(intf.mem_rden), 32'd0);
    @(negedge clk); #2 rst = 1'b1;
    repeat (3) @(posedge clk);

    // Stray start pulses and engine_done noise while busy.
    noise = 1'b1; spi_pct = 50; rdy_pct = 50; eng_fix = 0; eng_max = 4; fd0 = n_fd;
    pulse_start();
    wait_idle("t6", 3000);
    noise = 1'b0;
    check("t6_frame_done", 32'(n_fd - fd0), 32'd1);
    check("t6_timeout_err", 32'(intf.timeout_err), 32'd0);
    repeat (5) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/dither_frame_sequencer.md
Name: dither_frame_sequencer

Overview:
- Top-level frame scheduler for the pixel SRAM and the dithering engine; it sequences three phases per frame: LOAD (MCU bytes over SPI into SRAM), DITHER (per-pixel start/done handshake with the engine) and STREAM (SRAM read-back to the output byte stream).
- Only one requester owns the SRAM port at a time; ownership is reported on mem_sel for the external port mux.

Parameters:
- IMAGEX, 64, image width in pixels.
- IMAGEY, 64, image height in pixels.
- IMAGE_SIZE, IMAGEX*IMAGEY, pixels per frame.
- IMAGE_ADDR_WIDTH, $clog2(IMAGE_SIZE), pixel index width.
- RGB_SIZE, 8, pixel width.
- TIMEOUT_CYCLES, 64, maximum cycles allowed from engine_start to engine_done.

Ports:
- clk  in  1  system clock; all logic is on posedge.
- rst  in  1  asynchronous reset, active-low (asserted at 0).
- start  in  1  one-cycle pulse that begins a frame; honoured in IDLE only.
- abort  in  1  synchronous abort; forces IDLE on the next edge.
- spi_valid  in  1  spi_data holds a valid byte.
- spi_data  in  RGB_SIZE  incoming pixel byte.
- mcu_rx_rdy  out  1  sequencer accepts an SPI byte this cycle.
- engine_start  out  1  one-cycle pulse: dither pixel engine_idx.
- engine_idx  out  IMAGE_ADDR_WIDTH  pixel index for the engine.
- engine_done  in  1  one-cycle pulse: engine finished the current pixel.
- mem_sel  out  2  SRAM owner: 0 none, 1 loader, 2 engine, 3 streamer.
- mem_addr  out  16  SRAM address while mem_sel is 1 or 3; zero-extended index.
- mem_wdata  out  RGB_SIZE  SRAM write data (loader only).
- mem_wren  out  1  SRAM write enable.
- mem_rden  out  1  SRAM read enable.
- mem_q  in  RGB_SIZE  SRAM read data, valid 1 cycle after mem_rden.
- out_valid  out  1  out_data valid.
- out_data  out  RGB_SIZE  streamed dithered pixel.
- out_ready  in  1  downstream accepts out_data.
- busy  out  1  state is not IDLE.
- frame_done  out  1  one-cycle pulse at frame completion.
- timeout_err  out  1  sticky; set on engine timeout, cleared by the next accepted start.
- state  out  3  current state encoding, for debug.

Behaviour:
- States and encodings: IDLE=0, LOAD=1, D_ISSUE=2, D_WAIT=3, S_RD=4, S_CAP=5, S_HOLD=6, DONE=7.
- Reset (rst=0): state IDLE; idx=0; timeout counter=0. All outputs 0, including timeout_err and out_data. Reset takes effect immediately, including mid-frame.
- IDLE:
  - mem_sel=0.
  - start=1: go to LOAD, set idx=0, clear timeout_err.
  - Inputs other than start/abort are ignored.
- LOAD:
  - mem_sel=1 and mcu_rx_rdy=1.
  - When spi_valid=1, in the same cycle (combinational): mem_wren=1, mem_addr=idx, mem_wdata=spi_data.
  - Each accepted byte increments idx.
  - On acceptance at idx==IMAGE_SIZE-1: go to D_ISSUE and set idx=0.
  - spi_valid=0 stalls with no timeout.
- D_ISSUE:
  - mem_sel=2; engine_start=1 and engine_idx=idx for exactly one cycle.
  - Next state D_WAIT; timeout counter cleared.
- D_WAIT:
  - mem_sel=2; the counter increments each cycle.
  - engine_done=1 at idx==IMAGE_SIZE-1: go to S_RD, idx=0.
  - engine_done=1 otherwise: idx+1, go to D_ISSUE.
  - Counter reaches TIMEOUT_CYCLES with no done: set timeout_err=1, go to IDLE.
  - engine_done arriving in the same cycle as the counter expiry counts as a done; no error.
- engine_done outside D_WAIT is ignored. spi_valid outside LOAD is ignored and mcu_rx_rdy=0.
- S_RD: mem_sel=3, mem_rden=1, mem_addr=idx; next state S_CAP.
- S_CAP: mem_sel=3; out_data<=mem_q and out_valid<=1 at the edge; next state S_HOLD.
- S_HOLD:
  - out_valid=1; out_data is held stable until out_ready=1.
  - Handshake at idx==IMAGE_SIZE-1: out_valid<=0, go to DONE.
  - Handshake otherwise: out_valid<=0, idx+1, go to S_RD.
- Stream throughput is 1 pixel per 3 cycles.
- DONE: frame_done=1 for one cycle; go to IDLE.
- abort=1 in any state:
  - Next state IDLE; out_valid<=0; idx<=0; timeout_err unchanged.
  - abort has priority over every other transition.
  - Combinational strobes (mem_wren, engine_start) are still driven in the abort cycle per the current state.
- start while busy is ignored.
- idx has IMAGE_ADDR_WIDTH bits; it never increments past IMAGE_SIZE-1 (the phase exits first), so it cannot wrap.
- All strobes (engine_start, frame_done) are exactly one cycle wide.

Test Plan:
1. IMAGEX=IMAGEY=4. start, then 16 SPI bytes 0x00..0x0F with spi_valid held high; engine model answers engine_done 2 cycles after each start; out_ready tied 1.
   -> 16 engine_start pulses with idx 0..15; out_data stream 0x00..0x0F (echo model); one frame_done; busy drops after DONE.
2. LOAD with spi_valid toggling 1,0,0,1 patterns.
   -> mem_wren only on spi_valid=1 cycles; addresses consecutive 0..15; no skipped or duplicated index.
3. Engine never answers the idx=5 start.
   -> after TIMEOUT_CYCLES cycles: timeout_err=1, state=0, busy=0. A subsequent start clears timeout_err.
4. STREAM with out_ready held 0 for 10 cycles at idx=3.
   -> out_valid stays 1 and out_data is stable all 10 cycles; idx 4 is read only after the handshake.
5. abort pulsed in D_WAIT at idx=7; separately, rst driven 0 mid-STREAM.
   -> next state IDLE with out_valid=0 in both cases; rst clears all outputs asynchronously, without waiting for a clock edge.
6. start pulsed during LOAD and again during S_HOLD; engine_done injected during LOAD.
   -> no state or idx change; frame completes normally.
